// File: rtl/fetch_redirect.sv
// Fetch PC owner: issues imem requests and redirects on taken branches/jumps resolved in decode.
// Latency: target fetched right after the delay slot; redir_taken/redir_target one cycle after E.
// Backpressure: if_addr is held while if_req & ~if_ack; id_stall blocks resolution until it drops.
module fetch_redirect #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        if_req,
    output logic [31:0] if_addr,
    input  logic        if_ack,
    output logic        if_squash,
    input  logic        id_valid,
    input  logic        id_stall,
    input  logic [31:0] id_pc,
    input  logic        id_br,
    input  logic        bcres,
    input  logic [15:0] id_imm,
    input  logic        id_j,
    input  logic [25:0] id_jidx,
    input  logic        id_jr,
    input  logic [31:0] id_rs,
    output logic        redir_taken,
    output logic [31:0] redir_target,
    output logic [31:0] link_addr
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        HOLD_SLOT = 2'd2,
        HOLD_SQ   = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [31:0] tgt_q, tgt_nxt;
    logic [31:0] slot_pc;
    logic [31:0] br_off;
    logic [31:0] tgt;
    logic        ev;
    logic        accept;
    logic        in_slot;

    assign slot_pc   = id_pc + 32'd4;
    assign link_addr = id_pc + 32'd8;
    assign br_off    = {{14{id_imm[15]}}, id_imm, 2'b00};
    assign ev        = id_valid & ~id_stall & (id_jr | id_j | (id_br & bcres));
    assign in_slot   = (pc_q == slot_pc);
    assign if_addr   = pc_q;

    // Transfers resolved while a previous one is still pending sit in a delay slot and are dropped.
    assign accept    = ev & (state == RUN);

    always_comb begin
        tgt = slot_pc + br_off;
        if (id_jr) begin
            tgt = id_rs;
        end else if (id_j) begin
            tgt = {slot_pc[31:28], id_jidx, 2'b00};
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        tgt_nxt   = tgt_q;
        if_req    = 1'b0;
        if_squash = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = RUN;
            end
            RUN: begin
                if_req = 1'b1;
                if (ev) begin
                    if (if_ack) begin
                        // Slot already accepted earlier: this in-flight fetch is wrong-path.
                        if_squash = ~in_slot;
                        pc_nxt    = tgt;
                    end else begin
                        tgt_nxt   = tgt;
                        state_nxt = in_slot ? HOLD_SLOT : HOLD_SQ;
                    end
                end else if (if_ack) begin
                    pc_nxt = pc_q + 32'd4;
                end
            end
            HOLD_SLOT: begin
                if_req = 1'b1;
                if (if_ack) begin
                    pc_nxt    = tgt_q;
                    state_nxt = RUN;
                end
            end
            HOLD_SQ: begin
                if_req    = 1'b1;
                if_squash = if_ack;
                if (if_ack) begin
                    pc_nxt    = tgt_q;
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            tgt_q        <= 32'd0;
            redir_taken  <= 1'b0;
            redir_target <= 32'd0;
        end else begin
            pc_q        <= pc_nxt;
            tgt_q       <= tgt_nxt;
            redir_taken <= accept;
            if (accept) begin
                redir_target <= tgt;
            end
        end
    end

endmodule
